key_step_accum: RTL and testbench
=================================

KEY_STEP_ACCUM -- requirements
Module: key_step_accum

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 250000, number of consecutive stable clock cycles (5 ms at 50 MHz) that confirm a press or a release; legal range is 2 or more.
REQ-002 Port: CLOCK_50  input  1  the single clock; all state changes on its rising edge.
REQ-003 Port: RESET  input  1  synchronous, active-high reset.
REQ-004 Port: KEY_N  input  1  raw pushbutton, asynchronous to CLOCK_50, active-low (0 = pressed), bouncy.
REQ-005 Port: STEP_SEL  input  1  slide switch, asynchronous; 0 = add 1, 1 = add 2.
REQ-006 Port: SUM  output  8  registered running total; feeds the downstream binary-to-BCD/7-segment stage.
REQ-007 Port: SUM_VALID  output  1  one-cycle pulse in the cycle after SUM changes value or is re-written.
REQ-008 Port: OVF  output  1  sticky flag, set when an add exceeds 255.
REQ-009 The block SHALL use one clock, CLOCK_50, and one reset, RESET; RESET SHALL be synchronous and active-high.

Function
REQ-010 KEY_N and STEP_SEL SHALL each pass through a two-flop synchronizer before any use; pressed_s = NOT(synchronized KEY_N).
REQ-011 The FSM SHALL have four states: IDLE, PRESS_WAIT, HELD and RELEASE_WAIT; the debounce counter SHALL be ceil(log2(DEBOUNCE_CYCLES)) bits wide.
REQ-012 IDLE: when pressed_s=1, go to PRESS_WAIT with cnt=0; otherwise stay.
REQ-013 PRESS_WAIT: when pressed_s=0, go to IDLE (bounce rejected, no step); when cnt==DEBOUNCE_CYCLES-1, go to HELD and fire one step; otherwise cnt increments.
REQ-014 HELD: when pressed_s=0, go to RELEASE_WAIT with cnt=0; no further steps while held (no auto-repeat).
REQ-015 RELEASE_WAIT: when pressed_s=1, go to HELD (release bounce, no step); when cnt==DEBOUNCE_CYCLES-1, go to IDLE; otherwise cnt increments.
REQ-016 Step: SUM SHALL be written on the same edge as the PRESS_WAIT->HELD transition, with new value SUM + (synchronized STEP_SEL ? 2 : 1) sampled on that edge.
REQ-017 Latency: with KEY_N held low from the first sampling edge (edge 1), SUM SHALL update on edge DEBOUNCE_CYCLES+3, and SUM_VALID SHALL be high for exactly the following cycle.
REQ-018 Arithmetic: the 9-bit sum is computed; when bit 8 = 1, OVF SHALL be set to 1 and SUM SHALL take the low 8 bits (wrap), unless SATURATE_EN applies (REQ-024).
REQ-019 OVF SHALL remain set until RESET; at most one step SHALL occur per debounced press.

Reset
REQ-020 While RESET=1 on a rising edge: SUM=8'd0, SUM_VALID=0, OVF=0, cnt=0, synchronizer flops=1 (released), FSM=RELEASE_WAIT.
REQ-021 RESET SHALL take priority over any simultaneous step, transition or count.
REQ-022 A key held through reset release SHALL NOT generate a step; a fresh release of DEBOUNCE_CYCLES cycles followed by a debounced press is required.
REQ-023 RESET asserted in PRESS_WAIT SHALL abort the pending step.

Configuration
REQ-024 Macro KEY_STEP_ACCUM_SATURATE_EN defined: an overflowing add SHALL set SUM=8'd255 and set OVF=1. Macro not defined: SUM wraps modulo 256 and OVF is set; all other behaviour is identical.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 RESET 2 cycles, then KEY_N=1 for 20 cycles -> SUM=0, OVF=0, SUM_VALID never high.
REQ-026 STEP_SEL=0, KEY_N low for 30 cycles then high for 10 -> SUM 0->1 on edge 7 after the KEY_N fall, exactly one SUM_VALID pulse; a second identical press -> SUM=2.
REQ-027 KEY_N pattern (low 2, high 1) x5, then high -> SUM unchanged, no SUM_VALID; release bounce (high 2, low 1) in HELD -> no extra step.
REQ-028 From SUM=254 with STEP_SEL=1, one press -> SUM=0 and OVF=1 without the macro; SUM=255 and OVF=1 with the macro; a further press -> SUM=2 or 255 respectively, OVF still 1.
REQ-029 Hold KEY_N low, assert RESET for 1 cycle mid-PRESS_WAIT, keep KEY_N low 20 cycles -> SUM=0, no SUM_VALID; release for 10 cycles, then press -> SUM=1.

Source files
------------

// File: rtl/key_step_accum.sv
// Debounced pushbutton step accumulator: each clean press adds 1 or 2 to an 8-bit total.
// Optional macro KEY_STEP_ACCUM_SATURATE_EN clamps an overflowing add at 255 instead of wrapping.
module key_step_accum #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       KEY_N,
    input  logic       STEP_SEL,
    output logic [7:0] SUM,
    output logic       SUM_VALID,
    output logic       OVF,
    output logic [1:0] DBG_STATE
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic          key_meta_q;
    logic          key_sync_q;
    logic          sel_meta_q;
    logic          sel_sync_q;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    sum_q;
    logic          valid_q;
    logic          ovf_q;

    logic          pressed_s;
    logic [8:0]    sum_ext_d;
    logic [7:0]    sum_d;

    always_comb begin
        pressed_s = ~key_sync_q;
        sum_ext_d = {1'b0, sum_q} + (sel_sync_q ? 9'd2 : 9'd1);
`ifdef KEY_STEP_ACCUM_SATURATE_EN
        sum_d     = sum_ext_d[8] ? 8'hFF : sum_ext_d[7:0];
`else
        sum_d     = sum_ext_d[7:0];
`endif
    end

    // Reset lands in RELEASE_WAIT so a key held through reset must be released and re-pressed.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            sel_meta_q <= 1'b1;
            sel_sync_q <= 1'b1;
            state_q    <= RELEASE_WAIT;
            cnt_q      <= '0;
            sum_q      <= 8'd0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            key_meta_q <= KEY_N;
            key_sync_q <= key_meta_q;
            sel_meta_q <= STEP_SEL;
            sel_sync_q <= sel_meta_q;
            valid_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pressed_s) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed_s) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= HELD;
                        sum_q   <= sum_d;
                        valid_q <= 1'b1;
                        if (sum_ext_d[8]) ovf_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HELD: begin
                    if (!pressed_s) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed_s) begin
                        state_q <= HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign SUM       = sum_q;
    assign SUM_VALID = valid_q;
    assign OVF       = ovf_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_key_step_accum.sv
// Self-checking bench for key_step_accum with DEBOUNCE_CYCLES=4 and a run-length debounce model.
module tb_key_step_accum;

  localparam int D = 4;
`ifdef KEY_STEP_ACCUM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_n = 1'b1;
  logic       step_sel = 1'b0;
  logic [7:0] sum;
  logic       sum_valid;
  logic       ovf;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  key_step_accum #(.DEBOUNCE_CYCLES(D)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .KEY_N    (key_n),
    .STEP_SEL (step_sel),
    .SUM      (sum),
    .SUM_VALID(sum_valid),
    .OVF      (ovf),
    .DBG_STATE(dbg_state)
  );

  int total = 0;
  int bad = 0;

  // reference model: a press counts once the synchronized key has been down for D+1
  // consecutive samples while released; a release needs D+1 up samples (D right after reset)
  int         m_sum = 0;
  bit         m_ovf = 1'b0;
  bit         m_up = 1'b0;
  bit         m_last = 1'b0;
  int         m_run = 1;
  bit         key_h[2] = '{1'b1, 1'b1};
  bit         sel_h[2] = '{1'b1, 1'b1};
  logic [7:0] exp_q[$];
  int         valid_seen = 0;
  int         valid_err = 0;
  int         sb_err = 0;

  task automatic tick(input logic k, input logic s, input logic r);
    bit p;
    bit sel_s;
    bit step;
    int t;
    key_n = k;
    step_sel = s;
    rst = r;
    @(posedge clk);
    step = 1'b0;
    if (r) begin
      m_sum = 0; m_ovf = 1'b0; m_up = 1'b0; m_last = 1'b0; m_run = 1;
      key_h = '{1'b1, 1'b1};
      sel_h = '{1'b1, 1'b1};
      exp_q.delete();
    end else begin
      p = !key_h[1];
      sel_s = sel_h[1];
      key_h[1] = key_h[0]; key_h[0] = k;
      sel_h[1] = sel_h[0]; sel_h[0] = s;
      if (p == m_last) m_run++;
      else begin m_run = 1; m_last = p; end
      if (m_up && p && m_run == D + 1) begin
        step = 1'b1;
        m_up = 1'b0;
      end else if (!m_up && !p && m_run == D + 1) begin
        m_up = 1'b1;
      end
      if (step) begin
        t = m_sum + (sel_s ? 2 : 1);
        if (t > 255) begin
          m_ovf = 1'b1;
          m_sum = SAT ? 255 : t - 256;
        end else begin
          m_sum = t;
        end
        exp_q.push_back(8'(m_sum));
      end
    end
    #1;
    if (sum_valid === 1'b1) begin
      valid_seen++;
      if (exp_q.size() == 0) sb_err++;
      else begin
        if (sum !== exp_q[0]) sb_err++;
        void'(exp_q.pop_front());
      end
    end
    if (sum_valid !== step) valid_err++;
  endtask

  task automatic press(input logic s, input int low, input int high);
    for (int i = 0; i < low; i++) tick(1'b0, s, 1'b0);
    for (int i = 0; i < high; i++) tick(1'b1, s, 1'b0);
  endtask

  task automatic test_reset();
    int v0;
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    total++;
    if (sum !== 8'd0 || ovf !== 1'b0 || sum_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: sum=%0d ovf=%b valid=%b, want 0/0/0", sum, ovf, sum_valid);
    end
    total++;
    if (dbg_state !== 2'd3) begin
      bad++;
      $display("FAIL reset_state: got %0d want 3 (RELEASE_WAIT)", dbg_state);
    end
    v0 = valid_seen;
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b0);
    total++;
    if (sum !== 8'd0 || ovf !== 1'b0 || valid_seen != v0) begin
      bad++;
      $display("FAIL idle_release: sum=%0d ovf=%b pulses=%0d, want 0/0/0", sum, ovf, valid_seen - v0);
    end
    total++;
    if (dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL idle_state: got %0d want 0 (IDLE)", dbg_state);
    end
  endtask

  task automatic test_latency();
    logic [7:0] s0;
    int first_edge;
    int v0;
    s0 = sum;
    first_edge = -1;
    v0 = valid_seen;
    for (int i = 1; i <= 30; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (first_edge < 0 && sum !== s0) first_edge = i;
    end
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0);
    total++;
    if (first_edge != D + 3) begin
      bad++;
      $display("FAIL step_latency: sum changed on edge %0d, want %0d", first_edge, D + 3);
    end
    total++;
    if (sum !== 8'd1 || valid_seen - v0 != 1) begin
      bad++;
      $display("FAIL first_press: sum=%0d pulses=%0d, want 1/1", sum, valid_seen - v0);
    end
    press(1'b0, 30, 10);
    total++;
    if (sum !== 8'd2 || valid_seen - v0 != 2) begin
      bad++;
      $display("FAIL second_press: sum=%0d pulses=%0d, want 2/2", sum, valid_seen - v0);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] s0;
    int v0;
    s0 = 8'(m_sum);
    v0 = valid_seen;
    for (int n = 0; n < 5; n++) press(1'b0, 2, 1);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0);
    total++;
    if (sum !== s0 || valid_seen != v0) begin
      bad++;
      $display("FAIL press_bounce: sum=%0d pulses=%0d, want %0d/0", sum, valid_seen - v0, s0);
    end
    for (int i = 0; i < 15; i++) tick(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
    end
    press(1'b0, 5, 10);
    total++;
    if (sum !== s0 + 8'd1 || valid_seen - v0 != 1) begin
      bad++;
      $display("FAIL release_bounce: sum=%0d pulses=%0d, want %0d/1", sum, valid_seen - v0, s0 + 8'd1);
    end
  endtask

  task automatic test_overflow();
    logic s;
    int guard;
    guard = 0;
    while (m_sum != 254 && guard < 300) begin
      s = (m_sum <= 252) ? 1'($urandom_range(0, 1)) : 1'b0;
      press(s, $urandom_range(D + 3, D + 8), $urandom_range(D + 4, D + 9));
      guard++;
    end
    total++;
    if (sum !== 8'd254 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL reach_254: sum=%0d ovf=%b, want 254/0", sum, ovf);
    end
    press(1'b1, 12, 10);
    total++;
    if (sum !== (SAT ? 8'd255 : 8'd0) || ovf !== 1'b1) begin
      bad++;
      $display("FAIL overflow_add: sum=%0d ovf=%b, want %0d/1", sum, ovf, SAT ? 255 : 0);
    end
    press(1'b1, 12, 10);
    total++;
    if (sum !== (SAT ? 8'd255 : 8'd2) || ovf !== 1'b1) begin
      bad++;
      $display("FAIL after_overflow: sum=%0d ovf=%b, want %0d/1", sum, ovf, SAT ? 255 : 2);
    end
  endtask

  task automatic test_random();
    logic k;
    logic s;
    int len;
    k = 1'b1;
    for (int n = 0; n < 80; n++) begin
      k = ~k;
      s = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) tick(k, s, 1'b0);
    end
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 1'b0);
    total++;
    if (sum !== 8'(m_sum) || ovf !== m_ovf) begin
      bad++;
      $display("FAIL random_end: sum=%0d ovf=%b, want %0d/%b", sum, ovf, m_sum, m_ovf);
    end
    total++;
    if (valid_err != 0 || sb_err != 0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL valid_scoreboard: timing_err=%0d value_err=%0d pending=%0d, want 0/0/0",
               valid_err, sb_err, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_press();
    int v0;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
    total++;
    if (dbg_state !== 2'd1) begin
      bad++;
      $display("FAIL in_press_wait: state=%0d want 1", dbg_state);
    end
    tick(1'b0, 1'b0, 1'b1);
    v0 = valid_seen;
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b0);
    total++;
    if (sum !== 8'd0 || ovf !== 1'b0 || valid_seen != v0) begin
      bad++;
      $display("FAIL held_through_reset: sum=%0d ovf=%b pulses=%0d, want 0/0/0", sum, ovf, valid_seen - v0);
    end
    total++;
    if (dbg_state !== 2'd2) begin
      bad++;
      $display("FAIL held_after_reset: state=%0d want 2", dbg_state);
    end
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0);
    press(1'b0, 30, 10);
    total++;
    if (sum !== 8'd1 || valid_seen - v0 != 1) begin
      bad++;
      $display("FAIL press_after_reset: sum=%0d pulses=%0d, want 1/1", sum, valid_seen - v0);
    end
    total++;
    if (valid_err != 0 || sb_err != 0) begin
      bad++;
      $display("FAIL final_scoreboard: timing_err=%0d value_err=%0d, want 0/0", valid_err, sb_err);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_overflow();
    test_random();
    test_reset_mid_press();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
